// File: rtl/bin2bcd_scan.sv
// Binary to packed BCD by sequential shift-add-3, with a free-running multiplexed digit scanner.
// Optional leading-zero blanking of the scanned digits: BIN2BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bin2bcd_scan #(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_all,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     an
);

  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    sh_q;
  logic [SW-1:0]       scr_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q, ovf_q;
  logic [4*DIGITS-1:0] bcd_all_q;
  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [SW-1:0]       scr_adj;
  logic [3:0]          dig [DIGITS];

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_all_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_q    <= bin;
            scr_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {scr_q, sh_q} <= {scr_adj[SW-2:0], sh_q, 1'b0};
          cnt_q         <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= LATCH;
          end
        end
        LATCH: begin
          // Guard digit catches values beyond the displayable range.
          if (scr_q[SW-1 -: 4] != 4'd0) begin
            ovf_q     <= 1'b1;
            bcd_all_q <= '1;
          end else begin
            ovf_q     <= 1'b0;
            bcd_all_q <= scr_q[4*DIGITS-1:0];
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) dig[i] = bcd_all_q[4*i +: 4];
  end

`ifdef BIN2BCD_SCAN_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              seen;
  always_comb begin
    seen  = 1'b0;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen     = seen | (dig[i] != 4'd0);
      blank[i] = ~seen;
    end
    bcd_d = blank[idx_q] ? 4'hF : dig[idx_q];
  end
`else
  always_comb begin
    bcd_d = dig[idx_q];
  end
`endif

  assign an_d = ~(DIGITS'(1) << idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= ~DIGITS'(1);
      bcd_q <= 4'd0;
    end else begin
      an_q  <= an_d;
      bcd_q <= bcd_d;
      if (pre_q == PW'(SCAN_DIV - 1)) begin
        pre_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_all  = bcd_all_q;
  assign bcd      = bcd_q;
  assign an       = an_q;

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Directed bench for bin2bcd_scan: conversion latency, overflow, start-while-busy, scan order, async abort.
module tb_bin2bcd_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, overflow;
  logic [15:0] bcd_all;
  logic [3:0]  bcd;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;

  bin2bcd_scan #(.WIDTH(14), .DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow),
    .bcd_all(bcd_all), .bcd(bcd), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one conversion; returns at the negedge of the cycle where done must be high.
  task automatic conv(input string tag, input logic [13:0] v, input bit poke);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = -1;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (poke && k == 5) begin
        bin   = 14'd0;
        start = 1'b1;
      end
      if (poke && k == 6) start = 1'b0;
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = k;
    end
    chk({tag, "_busy_cycles"}, busy_n, 14);
    chk({tag, "_done_cycle"}, done_at, 15);
  endtask

  // exp holds the expected displayed nibble per digit index, index 0 in bits [3:0].
  task automatic scan_chk(input string tag, input logic [15:0] exp);
    logic [3:0] prev;
    logic [3:0] exp_an;
    int n;
    prev = an;
    n    = 0;
    while (!(an == 4'b1110 && prev != 4'b1110) && n < 40) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    chk({tag, "_sync"}, (n < 40) ? 1 : 0, 1);
    for (int s = 0; s < 5; s++) begin
      exp_an = ~(4'b0001 << (s % 4));
      chk({tag, "_an_first"}, an, exp_an);
      chk({tag, "_bcd"}, bcd, exp[4*(s%4) +: 4]);
      repeat (3) @(negedge clk);
      chk({tag, "_an_last"}, an, exp_an);
      @(negedge clk);
    end
  endtask

  initial begin
    int dn;
    logic [15:0] exp42, exp0;
`ifdef BIN2BCD_SCAN_LEADING_ZERO_BLANK_EN
    exp42 = 16'hFF42;
    exp0  = 16'hFFF0;
`else
    exp42 = 16'h0042;
    exp0  = 16'h0000;
`endif
    rst   = 1'b1;
    start = 1'b0;
    bin   = 14'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bcd_all", bcd_all, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_bcd", bcd, 0);
    rst = 1'b0;

    conv("c1234", 14'd1234, 1'b0);
    chk("c1234_val", bcd_all, 16'h1234);
    chk("c1234_ovf", overflow, 0);
    @(negedge clk);
    chk("c1234_done_pulse", done, 0);
    chk("c1234_hold", bcd_all, 16'h1234);

    scan_chk("scan1234", 16'h1234);

    conv("c9999", 14'd9999, 1'b1);
    chk("c9999_val", bcd_all, 16'h9999);
    @(negedge clk);
    chk("c9999_no_retrig", busy, 0);
    chk("c9999_hold", bcd_all, 16'h9999);
    conv("c0", 14'd0, 1'b0);
    chk("c0_val", bcd_all, 16'h0000);

    conv("c10000", 14'd10000, 1'b0);
    chk("c10000_val", bcd_all, 16'hFFFF);
    chk("c10000_ovf", overflow, 1);
    conv("c42", 14'd42, 1'b0);
    chk("c42_val", bcd_all, 16'h0042);
    chk("c42_ovf", overflow, 0);
    scan_chk("scan42", exp42);

    conv("c0b", 14'd0, 1'b0);
    chk("c0b_val", bcd_all, 16'h0000);
    scan_chk("scan0", exp0);

    // Abort a conversion of 5678 at SHIFT cycle 7.
    @(negedge clk);
    bin   = 14'd5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd_all", bcd_all, 0);
    chk("abort_an", an, 4'b1110);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_bcd_all_after", bcd_all, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
